// File: rtl/uart_pkg.sv
// Shared UART constants: default frame geometry and receiver/transmitter state codes.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int SB_TICK_DEF    = 16;
    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        EV_NONE      = 2'd0,
        EV_DONE      = 2'd1,
        EV_FRAME_ERR = 2'd2
    } uart_event_e;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width that stays legal (>=1) even for degenerate parameter values.
    function automatic int cnt_width(input int range_val);
        return (range_val > 2) ? $clog2(range_val) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Bundle of the receiver's serial-side and byte-side signals for use at the UART top level.
interface uart_rx_framer_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);
    logic                 rx;
    logic                 tick;
    logic                 rx_done;
    logic                 frame_err;
    logic [DATA_BITS-1:0] data;

    modport master (
        output rx, tick,
        input  rx_done, frame_err, data
    );

    modport slave (
        input  rx, tick,
        output rx_done, frame_err, data
    );
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer with a parameterized reset level (idle level of the line).
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data capture, stop-bit check.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int SB_TICK    = SB_TICK_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic                 o_rx_done,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err
);
    localparam int S_W = cnt_width(imax(OVERSAMPLE, SB_TICK));
    localparam int N_W = cnt_width(DATA_BITS);

    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic [1:0]           r_state;
    logic [S_W-1:0]       r_s;
    logic [N_W-1:0]       r_n;
    logic [DATA_BITS-1:0] r_b;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rx_done;
    logic                 r_frame_err;

    rx_sync #(.RST_VAL(1'b1)) u_rx_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_b         <= '0;
            r_data      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Start detection is not tick-gated so a start right after STOP is caught.
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (r_s == S_HALF) begin
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (r_s == S_BIT) begin
                            r_b <= {w_rx_s, r_b[DATA_BITS-1:1]};
                            r_s <= '0;
                            if (r_n == N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + N_W'(1);
                            end
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (i_tick) begin
                        if (r_s == S_STOP) begin
                            r_state <= ST_IDLE;
                            if (w_rx_s) begin
                                r_data    <= r_b;
                                r_rx_done <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_s <= r_s + S_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rx_done   = r_rx_done;
    assign o_frame_err = r_frame_err;
    assign o_data      = r_data;
endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: frames are generated bit-by-bit from a byte-level model.
module tb_uart_rx_framer;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_en = 1'b1;
    int   cyc = 0;

    uart_rx_framer_if #(.DATA_BITS(8)) bus ();

    uart_rx_framer dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (bus.rx),
        .i_tick      (bus.tick),
        .o_rx_done   (bus.rx_done),
        .o_data      (bus.data),
        .o_frame_err (bus.frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_last = 8'h00;
    int         checks = 0;
    int         failures = 0;
    int         done_seen = 0;
    int         err_seen = 0;
    int         done_exp = 0;
    int         err_exp = 0;
    logic [31:0] word = 32'h0;

    // Tick every 4th cycle, updated on the falling edge so it is stable at the sampling edge.
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.tick = tick_en && (cyc % 4 == 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expected event per output pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_done && bus.frame_err) begin
                checks++;
                failures++;
                $display("FAIL both_pulses: got done=1 err=1, required at most one");
            end else if (bus.rx_done || bus.frame_err) begin
                ev_t e;
                checks++;
                if (bus.rx_done) begin
                    done_seen++;
                    word = {bus.data, word[31:8]};
                end else begin
                    err_seen++;
                end
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b data=%02h, required no pulse",
                             bus.rx_done, bus.frame_err, bus.data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.frame_err != e.is_err || bus.data != e.data) begin
                        failures++;
                        $display("FAIL event: got err=%0b data=%02h, required err=%0b data=%02h",
                                 bus.frame_err, bus.data, e.is_err, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic set_rx(input logic v);
        @(negedge clk);
        bus.rx = v;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.tick) @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_last = 8'h00;
    endtask

    // pause_bit / abort_bit < 0 disable those options.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int pause_bit, input int abort_bit);
        if (abort_bit < 0) begin
            if (stop_ok) begin
                exp_q.push_back('{is_err: 1'b0, data: d});
                model_last = d;
                done_exp++;
            end else begin
                exp_q.push_back('{is_err: 1'b1, data: model_last});
                err_exp++;
            end
        end
        set_rx(1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            set_rx(d[i]);
            if (i == abort_bit) begin
                wait_ticks(OS / 2);
                do_reset();
                return;
            end else if (i == pause_bit) begin
                wait_ticks(OS / 2);
                @(negedge clk);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(OS / 2);
            end else begin
                wait_ticks(OS);
            end
        end
        set_rx(stop_ok);
        // A bad stop bit is shortened so the line is idle again before the receiver
        // re-qualifies it as a start bit; the idle gap then separates frames.
        wait_ticks(stop_ok ? OS : 12);
        set_rx(1'b1);
        if (!stop_ok) wait_ticks(OS);
    endtask

    initial begin
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", bus.data, 8'h00);
        check("reset_done", bus.rx_done, 1'b0);
        check("reset_err", bus.frame_err, 1'b0);
        rst = 1'b0;
        wait_ticks(20);

        send_frame(8'hA5, 1'b1, -1, -1);
        wait_ticks(20);
        check("a5_data", bus.data, 8'hA5);
        check("a5_done_count", done_seen, 1);
        check("a5_err_count", err_seen, 0);

        set_rx(1'b0);
        wait_ticks(5);
        set_rx(1'b1);
        wait_ticks(40);
        check("glitch_done_count", done_seen, 1);
        check("glitch_err_count", err_seen, 0);

        send_frame(8'h3C, 1'b1, -1, -1);
        send_frame(8'h81, 1'b0, -1, -1);
        wait_ticks(20);
        check("ferr_count", err_seen, 1);
        check("ferr_data_kept", bus.data, 8'h3C);

        send_frame(8'h78, 1'b1, -1, -1);
        send_frame(8'h56, 1'b1, -1, -1);
        send_frame(8'h34, 1'b1, -1, -1);
        send_frame(8'h12, 1'b1, -1, -1);
        wait_ticks(20);
        check("word_assembled", word, 32'h12345678);

        send_frame(8'hFF, 1'b1, -1, 3);
        check("abort_data_zero", bus.data, 8'h00);
        check("abort_done_low", bus.rx_done, 1'b0);
        wait_ticks(20);
        send_frame(8'h42, 1'b1, -1, -1);
        wait_ticks(20);
        check("after_reset_data", bus.data, 8'h42);

        send_frame(8'h5A, 1'b1, 4, -1);
        wait_ticks(20);
        check("pause_data", bus.data, 8'h5A);

        for (int k = 0; k < 20; k++) begin
            logic [7:0] rb;
            bit         sok;
            int         gap;
            rb  = 8'($urandom);
            sok = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            send_frame(rb, sok, -1, -1);
            if (gap != 0) wait_ticks(gap * OS);
        end
        wait_ticks(40);
        check("queue_drained", exp_q.size(), 0);
        check("total_done", done_seen, done_exp);
        check("total_err", err_seen, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 SHALL have parameter SB_TICK, default 16: oversample ticks spent sampling the stop bit.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: oversample ticks per bit period.
REQ-004 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line; idle level is 1.
REQ-007 SHALL have port i_tick, input, 1 bit: one-cycle enable at OVERSAMPLE times the baud rate, driven by an external baud generator.
REQ-008 SHALL have port o_rx_done, output, 1 bit: one-cycle pulse marking a valid received byte; it drives the word assembler's i_data_ready.
REQ-009 SHALL have port o_data, output, DATA_BITS bits: last valid received byte.
REQ-010 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the sampled stop bit is 0.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value (rx_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL hold tick counter s (width clog2(max(OVERSAMPLE,SB_TICK))) and bit counter n (width clog2(DATA_BITS)); both advance only in cycles where i_tick=1.
REQ-014 IDLE: when rx_s=0, SHALL go to START with s=0; otherwise stay in IDLE.
REQ-015 START: on a tick with s=OVERSAMPLE/2-1, SHALL go to DATA with s=0 and n=0 if rx_s=0, and otherwise return to IDLE as a false start with no output pulse; on any other tick, s increments.
REQ-016 DATA: on a tick with s=OVERSAMPLE-1, SHALL shift rx_s into the MSB of shift register b (b = {rx_s, b[DATA_BITS-1:1]}) and set s=0; SHALL go to STOP if n=DATA_BITS-1, otherwise increment n.
REQ-017 STOP: on a tick with s=SB_TICK-1, SHALL return to IDLE; if rx_s=1, o_data<=b and o_rx_done=1 for exactly one cycle; if rx_s=0, o_frame_err=1 for one cycle and o_data stays unchanged.
REQ-018 o_rx_done and o_frame_err SHALL be registered and asserted in the cycle after the clock edge that samples the final stop tick; they are never both high.
REQ-019 o_data SHALL hold its value between valid frames; downstream may sample it on any cycle with o_rx_done=1 or later.
REQ-020 When i_tick stays 0, state, s, n and b SHALL freeze; there is no timeout.
REQ-021 A line held low (break) SHALL yield one o_frame_err pulse per frame time and no o_rx_done.
REQ-022 A new start bit detected in IDLE in the cycle immediately after STOP exits SHALL be accepted (back-to-back frames).

Reset
REQ-023 On i_reset=1, state SHALL go to IDLE, s=0, n=0, b=0, o_data=0, o_rx_done=0, o_frame_err=0, and the synchronizer flops SHALL be set to 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; the first full frame after reset release SHALL be received correctly.

Structure
REQ-025 State encodings (2-bit localparams) and default OVERSAMPLE/DATA_BITS/SB_TICK SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-026 The synchronizer SHALL be one sub-module, rx_sync (2-flop, reset value parameterized), so it can be reused.
REQ-027 The baud tick generator SHALL NOT be part of this block; it is instantiated beside it at the UART top level.

Verification
REQ-028 With i_tick every 4th cycle, send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> o_data=0xA5, exactly one o_rx_done pulse, o_frame_err stays 0.
REQ-029 Drive an i_rx low glitch lasting 5 ticks, then return high -> FSM returns to IDLE, no o_rx_done, no o_frame_err.
REQ-030 After receiving 0x3C, send 0x81 with stop bit 0 -> one o_frame_err pulse, no o_rx_done, o_data still 0x3C.
REQ-031 Send 0x78, 0x56, 0x34, 0x12 back-to-back into the chained word assembler -> four o_rx_done pulses, assembler outputs 0x12345678 with a one-cycle ready.
REQ-032 Assert i_reset during the 4th data bit of 0xFF, then send 0x42 -> no pulse for the aborted frame, o_data=0x42 with one o_rx_done.
REQ-033 Hold i_tick=0 for 100 cycles in the middle of DATA, then resume -> byte 0x5A still received correctly.
